// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing uart_tx among three mailbox sources
//
// Purpose: three one-deep mailboxes (mole position, score, timer) are drained
// round-robin into uart_tx as tagged packets: tag byte, payload byte and,
// with CHECKSUM_EN defined, a trailing XOR checksum byte.
//
// Optional feature macro: CHECKSUM_EN (adds tag^payload as a third byte).
//
// Ports:
//   clock            in   system clock, 100MHz
//   reset            in   synchronous, active-low reset
//   req[2:0]         in   per-source post strobe, bit i = source i
//   payload0..2      in   source bytes, sampled when the matching req bit is 1
//   flush            in   clears all mailboxes; an in-flight packet completes
//   tx_busy          in   busy flag from uart_tx
//   tx_start         out  one-cycle start pulse to uart_tx
//   tx_data[7:0]     out  byte to uart_tx, held from tx_start to byte end
//   pending[2:0]     out  mailbox-full flags
//   sched_busy       out  high whenever the FSM is not idle
//   grant_id[1:0]    out  source of the in-flight packet
//   pkt_done         out  one-cycle pulse when the last byte completes
//   overwrite_count  out  saturating count of mailbox overwrites

module uart_tx_scheduler #(
    parameter logic [7:0] TAG0        = 8'h4D,
    parameter logic [7:0] TAG1        = 8'h53,
    parameter logic [7:0] TAG2        = 8'h54,
    parameter int         ACK_TIMEOUT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] payload0,
    input  logic [7:0] payload1,
    input  logic [7:0] payload2,
    input  logic       flush,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [2:0] pending,
    output logic       sched_busy,
    output logic [1:0] grant_id,
    output logic       pkt_done,
    output logic [7:0] overwrite_count
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SEND_HDR = 4'd1;
    localparam logic [3:0] S_ACK_HDR  = 4'd2;
    localparam logic [3:0] S_DONE_HDR = 4'd3;
    localparam logic [3:0] S_SEND_PAY = 4'd4;
    localparam logic [3:0] S_ACK_PAY  = 4'd5;
    localparam logic [3:0] S_DONE_PAY = 4'd6;
`ifdef CHECKSUM_EN
    localparam logic [3:0] S_SEND_CHK = 4'd7;
    localparam logic [3:0] S_ACK_CHK  = 4'd8;
    localparam logic [3:0] S_DONE_CHK = 4'd9;
    localparam logic [3:0] S_LAST     = S_DONE_CHK;
`else
    localparam logic [3:0] S_LAST     = S_DONE_PAY;
`endif

    // ACK states last at most ACK_TIMEOUT cycles: counter runs 0..ACK_LAST.
    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

    logic [3:0] state;
    logic [1:0] last;
    logic [7:0] shadow;
    logic [7:0] ack_cnt;
    logic [7:0] mbox [3];
    logic [7:0] pay_in [3];

    logic [1:0] idx1;
    logic [1:0] idx2;
    logic [1:0] grant_sel;
    logic       grant_now;
    logic [2:0] granted;
    logic [2:0] ovw;
    logic [8:0] ovw_sum;

    function automatic logic [7:0] tag_of(input logic [1:0] id);
        case (id)
            2'd1:    tag_of = TAG1;
            2'd2:    tag_of = TAG2;
            default: tag_of = TAG0;
        endcase
    endfunction

    assign pay_in[0] = payload0;
    assign pay_in[1] = payload1;
    assign pay_in[2] = payload2;

    // Round-robin search starting just after the last granted source.
    always_comb begin
        idx1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        idx2 = (idx1 == 2'd2) ? 2'd0 : idx1 + 2'd1;
        if (pending[idx1])
            grant_sel = idx1;
        else if (pending[idx2])
            grant_sel = idx2;
        else
            grant_sel = last;
    end

    assign grant_now = (state == S_IDLE) && (pending != 3'b000) && !tx_busy;
    assign granted   = grant_now ? 3'(3'b001 << grant_sel) : 3'b000;

    // An overwrite is a post onto a full mailbox that is not leaving this cycle.
    assign ovw     = req & pending & ~granted;
    assign ovw_sum = {1'b0, overwrite_count} + 9'(ovw[0]) + 9'(ovw[1]) + 9'(ovw[2]);

    // Start is gated by tx_busy so a stray busy can never see a second start.
    assign tx_start = ((state == S_SEND_HDR) || (state == S_SEND_PAY)
`ifdef CHECKSUM_EN
                       || (state == S_SEND_CHK)
`endif
                      ) && !tx_busy;

    assign pkt_done   = (state == S_LAST) && !tx_busy;
    assign sched_busy = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending         <= 3'b000;
            overwrite_count <= 8'd0;
            for (int i = 0; i < 3; i++)
                mbox[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req[i]) begin
                    mbox[i]    <= pay_in[i];
                    pending[i] <= 1'b1;
                end else if (granted[i] || flush) begin
                    pending[i] <= 1'b0;
                end
            end
            overwrite_count <= ovw_sum[8] ? 8'hFF : ovw_sum[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            last     <= 2'd2;
            grant_id <= 2'd0;
            tx_data  <= 8'd0;
            shadow   <= 8'd0;
            ack_cnt  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        last     <= grant_sel;
                        grant_id <= grant_sel;
                        shadow   <= mbox[grant_sel];
                        tx_data  <= tag_of(grant_sel);
                        state    <= S_SEND_HDR;
                    end
                end
                S_SEND_HDR: begin
                    if (!tx_busy) begin
                        ack_cnt <= 8'd0;
                        state   <= S_ACK_HDR;
                    end
                end
                S_ACK_HDR: begin
                    if (tx_busy || ack_cnt == ACK_LAST)
                        state <= S_DONE_HDR;
                    else
                        ack_cnt <= ack_cnt + 8'd1;
                end
                S_DONE_HDR: begin
                    if (!tx_busy) begin
                        tx_data <= shadow;
                        state   <= S_SEND_PAY;
                    end
                end
                S_SEND_PAY: begin
                    if (!tx_busy) begin
                        ack_cnt <= 8'd0;
                        state   <= S_ACK_PAY;
                    end
                end
                S_ACK_PAY: begin
                    if (tx_busy || ack_cnt == ACK_LAST)
                        state <= S_DONE_PAY;
                    else
                        ack_cnt <= ack_cnt + 8'd1;
                end
                S_DONE_PAY: begin
                    if (!tx_busy) begin
`ifdef CHECKSUM_EN
                        tx_data <= tag_of(grant_id) ^ shadow;
                        state   <= S_SEND_CHK;
`else
                        state   <= S_IDLE;
`endif
                    end
                end
`ifdef CHECKSUM_EN
                S_SEND_CHK: begin
                    if (!tx_busy) begin
                        ack_cnt <= 8'd0;
                        state   <= S_ACK_CHK;
                    end
                end
                S_ACK_CHK: begin
                    if (tx_busy || ack_cnt == ACK_LAST)
                        state <= S_DONE_CHK;
                    else
                        ack_cnt <= ack_cnt + 8'd1;
                end
                S_DONE_CHK: begin
                    if (!tx_busy)
                        state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler

module tb_uart_tx_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] req = 3'b000;
    logic [7:0] payload0 = 8'h00;
    logic [7:0] payload1 = 8'h00;
    logic [7:0] payload2 = 8'h00;
    logic       flush = 1'b0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [2:0] pending;
    logic       sched_busy;
    logic [1:0] grant_id;
    logic       pkt_done;
    logic [7:0] overwrite_count;

`ifdef CHECKSUM_EN
    localparam int NB = 3;
    localparam int PD = 19;
`else
    localparam int NB = 2;
    localparam int PD = 13;
`endif

    logic       mbusy = 1'b0;
    logic       hold_busy = 1'b0;
    int         busy_len = 20;
    int         n_start = 0;
    int         done_n = 0;
    logic [7:0] blog [64];
    int         vectors = 0;
    int         miscompares = 0;

    assign tx_busy = mbusy | hold_busy;

    uart_tx_scheduler dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .payload0        (payload0),
        .payload1        (payload1),
        .payload2        (payload2),
        .flush           (flush),
        .tx_busy         (tx_busy),
        .tx_start        (tx_start),
        .tx_data         (tx_data),
        .pending         (pending),
        .sched_busy      (sched_busy),
        .grant_id        (grant_id),
        .pkt_done        (pkt_done),
        .overwrite_count (overwrite_count)
    );

    always #5 clock = ~clock;

    // uart_tx model: logs each started byte, raises busy the cycle after start
    initial begin
        int   bcnt;
        logic ps;
        bcnt = 0;
        forever begin
            @(negedge clock);
            ps = tx_start;
            if (tx_start) begin
                if (n_start < 64) blog[n_start] = tx_data;
                n_start++;
            end
            if (pkt_done) done_n++;
            @(posedge clock);
            #1;
            if (ps && busy_len > 0) begin
                mbusy = 1'b1;
                bcnt  = busy_len;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) mbusy = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pkts(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (done_n < target && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 32'(done_n >= target), 1);
    endtask

    initial begin
        int k;

        // reset state
        reset = 1'b0;
        step(2);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_sched_busy", 32'(sched_busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_pkt_done", 32'(pkt_done), 0);
        chk("rst_ovw", 32'(overwrite_count), 0);
        reset = 1'b1;
        step(1);

        // single post, idle link, latency
        payload0 = 8'h04; req = 3'b001;
        step(1);
        req = 3'b000;
        chk("t1_pending", 32'(pending), 'h1);
        chk("t1_idle", 32'(sched_busy), 0);
        step(1);
        chk("t1_start", 32'(tx_start), 1);
        chk("t1_hdr", 32'(tx_data), 'h4D);
        chk("t1_gid", 32'(grant_id), 0);
        chk("t1_pclr", 32'(pending), 0);
        wait_pkts(1, 200, "t1_done");
        chk("t1_b0", 32'(blog[0]), 'h4D);
        chk("t1_b1", 32'(blog[1]), 'h04);
        chk("t1_nbytes", 32'(n_start), 32'(NB));
        chk("t1_pend_end", 32'(pending), 0);

        // three sources in one cycle, from fresh round-robin pointer
        reset = 1'b0; step(1); reset = 1'b1;
        n_start = 0; done_n = 0;
        payload0 = 8'h01; payload1 = 8'h07; payload2 = 8'h1E; req = 3'b111;
        step(1);
        req = 3'b000;
        wait_pkts(3, 400, "t2_done");
        chk("t2_m_tag", 32'(blog[0]), 'h4D);
        chk("t2_m_pay", 32'(blog[1]), 'h01);
        chk("t2_s_tag", 32'(blog[NB]), 'h53);
        chk("t2_s_pay", 32'(blog[NB+1]), 'h07);
        chk("t2_t_tag", 32'(blog[2*NB]), 'h54);
        chk("t2_t_pay", 32'(blog[2*NB+1]), 'h1E);
        n_start = 0; done_n = 0;
        payload0 = 8'hA0; payload2 = 8'hA2; req = 3'b101;
        step(1);
        req = 3'b000;
        wait_pkts(2, 400, "t2_next_done");
        chk("t2_next_first", 32'(blog[0]), 'h4D);
        chk("t2_next_pay", 32'(blog[1]), 'hA0);
        chk("t2_next_second", 32'(blog[NB]), 'h54);

        // overwrite while a source 0 packet is in flight
        reset = 1'b0; step(1); reset = 1'b1;
        n_start = 0; done_n = 0;
        payload0 = 8'h11; req = 3'b001;
        step(1);
        req = 3'b000;
        step(2);
        payload1 = 8'h05; req = 3'b010;
        step(1);
        payload1 = 8'h06;
        step(1);
        req = 3'b000;
        chk("t3_ovw1", 32'(overwrite_count), 1);
        chk("t3_pending", 32'(pending), 'h2);
        wait_pkts(2, 400, "t3_done");
        chk("t3_m_pay", 32'(blog[1]), 'h11);
        chk("t3_s_tag", 32'(blog[NB]), 'h53);
        chk("t3_s_pay", 32'(blog[NB+1]), 'h06);

        // saturation: link held busy so source 2 is never granted
        hold_busy = 1'b1;
        payload2 = 8'h77; req = 3'b100;
        step(1);
        step(253);
        chk("t3_ovw254", 32'(overwrite_count), 254);
        step(10);
        chk("t3_ovw255", 32'(overwrite_count), 255);
        req = 3'b000; flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("t3_flush_pend", 32'(pending), 0);
        chk("t3_flush_idle", 32'(sched_busy), 0);
        hold_busy = 1'b0;
        step(2);

        // ACK timeout: busy never rises
        busy_len = 0; n_start = 0; done_n = 0;
        payload0 = 8'hAA; req = 3'b001;
        step(1);
        req = 3'b000;
        step(PD - 2);
        chk("t4_pd_early", 32'(pkt_done), 0);
        step(1);
        chk("t4_pd", 32'(pkt_done), 1);
        step(1);
        chk("t4_nstarts", 32'(n_start), 32'(NB));
        chk("t4_b0", 32'(blog[0]), 'h4D);
        chk("t4_b1", 32'(blog[1]), 'hAA);
        chk("t4_idle", 32'(sched_busy), 0);

        // flush mid-packet
        busy_len = 20; n_start = 0; done_n = 0;
        payload0 = 8'h22; req = 3'b001;
        step(1);
        req = 3'b000;
        step(3);
        payload1 = 8'h33; payload2 = 8'h44; req = 3'b110;
        step(1);
        req = 3'b000;
        chk("t5_pend110", 32'(pending), 'h6);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("t5_pend0", 32'(pending), 0);
        chk("t5_inflight", 32'(sched_busy), 1);
        wait_pkts(1, 200, "t5_done");
        step(10);
        chk("t5_nstarts", 32'(n_start), 32'(NB));
        chk("t5_b1", 32'(blog[1]), 'h22);
        chk("t5_idle", 32'(sched_busy), 0);

        // reset while in ACK_PAY
        n_start = 0; done_n = 0;
        payload1 = 8'h55; req = 3'b010;
        step(1);
        payload0 = 8'h66; req = 3'b001;
        step(1);
        req = 3'b000;
        k = 0;
        while (n_start < 2 && k < 200) begin
            step(1);
            k++;
        end
        chk("t6_reach_pay", 32'(n_start), 2);
        chk("t6_busy_pre", 32'(sched_busy), 1);
        reset = 1'b0;
        step(1);
        chk("t6_tx_start", 32'(tx_start), 0);
        chk("t6_tx_data", 32'(tx_data), 0);
        chk("t6_pending", 32'(pending), 0);
        chk("t6_sched_busy", 32'(sched_busy), 0);
        chk("t6_grant_id", 32'(grant_id), 0);
        chk("t6_pkt_done", 32'(pkt_done), 0);
        chk("t6_ovw", 32'(overwrite_count), 0);
        reset = 1'b1;
        step(40);
        chk("t6_no_reissue", 32'(n_start), 2);

`ifdef CHECKSUM_EN
        n_start = 0; done_n = 0;
        payload2 = 8'h1E; req = 3'b100;
        step(1);
        req = 3'b000;
        wait_pkts(1, 200, "t7_done");
        chk("t7_b0", 32'(blog[0]), 'h54);
        chk("t7_b1", 32'(blog[1]), 'h1E);
        chk("t7_b2", 32'(blog[2]), 'h4A);
        chk("t7_nbytes", 32'(n_start), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
